// File: rtl/analog_rx.sv
// analog_rx: accepts a spin vector, strobes the analog macro load, holds start for a programmable
// number of cycles, then raises a sticky compute-finish level until the next vector is accepted.
module analog_rx #(
   parameter int num_spin            = 256,
   parameter int counter_bitwidth    = 8,
   parameter int default_cmpt_cycles = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic                        rx_configure_enable_i,
   input  logic [counter_bitwidth-1:0] cmpt_cycles_i,
   input  logic                        spin_valid_i,
   output logic                        spin_ready_o,
   input  logic [num_spin-1:0]         spin_i,
   output logic [num_spin-1:0]         spin_o,
   output logic                        analog_macro_load_o,
   output logic                        analog_macro_start_o,
   output logic                        analog_macro_cmpt_finish_o,
   output logic                        analog_rx_idle_o
);
   typedef enum logic [1:0] {IDLE, LOAD, CMPT} state_t;
   localparam logic [counter_bitwidth-1:0] ONE = counter_bitwidth'(1);
   state_t                      r_state, w_state_nxt;
   logic [counter_bitwidth-1:0] r_cnt, w_cnt_nxt, r_cmpt_cycles, r_n;
   logic [num_spin-1:0]         r_spin;
   logic                        r_finish, w_finish_nxt, w_hs, w_idle;
   assign w_idle                     = r_state == IDLE;
   assign spin_ready_o               = en_i && w_idle;
   assign w_hs                       = spin_valid_i && spin_ready_o;
   assign spin_o                     = r_spin;
   assign analog_macro_load_o        = r_state == LOAD;
   assign analog_macro_start_o       = r_state == CMPT;
   assign analog_macro_cmpt_finish_o = r_finish;
   assign analog_rx_idle_o           = w_idle;
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_finish_nxt = r_finish;
      if (!en_i) begin
         w_state_nxt  = IDLE;
         w_cnt_nxt    = '0;
         w_finish_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_hs) begin
               w_state_nxt  = LOAD;
               w_finish_nxt = 1'b0;
            end
            LOAD: begin
               w_state_nxt = CMPT;
               w_cnt_nxt   = ONE;
            end
            CMPT: if (r_cnt >= r_n) begin
               w_state_nxt  = IDLE;
               w_cnt_nxt    = '0;
               w_finish_nxt = 1'b1;
            end else w_cnt_nxt = r_cnt + ONE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end
   // A config strobe coinciding with the handshake is already in r_cmpt_cycles when LOAD samples it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_finish      <= 1'b0;
         r_spin        <= '0;
         r_n           <= ONE;
         r_cmpt_cycles <= counter_bitwidth'(default_cmpt_cycles);
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_finish <= w_finish_nxt;
         if (w_hs) r_spin <= spin_i;
         if (en_i && rx_configure_enable_i && w_idle) r_cmpt_cycles <= cmpt_cycles_i;
         if (en_i && r_state == LOAD) r_n <= (r_cmpt_cycles == '0) ? ONE : r_cmpt_cycles;
      end
   end
endmodule

// File: tb/tb_analog_rx.sv
// tb_analog_rx: scoreboard bench; each accepted vector queues its expected spin and compute length.
module tb_analog_rx;
   localparam int NS = 256;
   typedef struct { logic [NS-1:0] spin; int n; } exp_t;
   logic          clk_i = 0, rst_i = 1, en_i = 1, rx_configure_enable_i = 0, spin_valid_i = 0;
   logic [7:0]    cmpt_cycles_i = '0;
   logic [NS-1:0] spin_i = '0, spin_o;
   logic          spin_ready_o, analog_macro_load_o, analog_macro_start_o;
   logic          analog_macro_cmpt_finish_o, analog_rx_idle_o;
   exp_t          exp_q[$];
   int            tests_run = 0, failed = 0;

   analog_rx dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .rx_configure_enable_i(rx_configure_enable_i),
      .cmpt_cycles_i(cmpt_cycles_i), .spin_valid_i(spin_valid_i), .spin_ready_o(spin_ready_o),
      .spin_i(spin_i), .spin_o(spin_o), .analog_macro_load_o(analog_macro_load_o),
      .analog_macro_start_o(analog_macro_start_o),
      .analog_macro_cmpt_finish_o(analog_macro_cmpt_finish_o), .analog_rx_idle_o(analog_rx_idle_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [NS-1:0] pat(input logic [7:0] b);
      return {(NS/8){b}};
   endfunction

   task automatic cfg(input logic [7:0] v);
      rx_configure_enable_i = 1; cmpt_cycles_i = v;
      @(negedge clk_i);
      rx_configure_enable_i = 0;
   endtask

   // Starts at a negedge in IDLE; measures one computation until finish rises (bounded).
   task automatic run_hs(input logic [NS-1:0] s, input bit hold, input int cfg_cyc, input logic [7:0] cfg_val,
                         output int n_load, output int n_start, output int n_cyc, output int n_ready);
      spin_i = s; spin_valid_i = 1;
      @(posedge clk_i);
      @(negedge clk_i);
      if (!hold) spin_valid_i = 0;
      n_load = 0; n_start = 0; n_ready = 0; n_cyc = 1;
      while (analog_macro_cmpt_finish_o !== 1'b1 && n_cyc < 600) begin
         n_load += int'(analog_macro_load_o);
         n_start += int'(analog_macro_start_o);
         n_ready += int'(spin_ready_o);
         rx_configure_enable_i = (n_cyc == cfg_cyc); cmpt_cycles_i = cfg_val;
         @(negedge clk_i);
         n_cyc++;
      end
      rx_configure_enable_i = 0;
   endtask

   task automatic check_run(input string nm, input int n_load, input int n_start, input int n_cyc);
      exp_t e;
      tests_run++;
      if (exp_q.size() == 0) begin
         failed++; $display("FAIL %s: scoreboard empty", nm);
         return;
      end
      e = exp_q.pop_front();
      if (spin_o !== e.spin) begin failed++; $display("FAIL %s spin_o: got %h want %h", nm, spin_o[31:0], e.spin[31:0]); end
      tests_run++;
      if (n_load !== 1) begin failed++; $display("FAIL %s load cycles: got %0d want 1", nm, n_load); end
      tests_run++;
      if (n_start !== e.n) begin failed++; $display("FAIL %s start cycles: got %0d want %0d", nm, n_start, e.n); end
      tests_run++;
      if (n_cyc !== e.n + 2) begin failed++; $display("FAIL %s finish timing: got %0d want %0d", nm, n_cyc, e.n + 2); end
   endtask

   task automatic test_reset();
      #1;
      tests_run++;
      if ({spin_o != '0, analog_macro_load_o, analog_macro_start_o, analog_macro_cmpt_finish_o} !== 4'b0) begin
         failed++; $display("FAIL reset outputs: got %b want 0000", {spin_o != '0, analog_macro_load_o, analog_macro_start_o, analog_macro_cmpt_finish_o});
      end
      tests_run++;
      if ({analog_rx_idle_o, spin_ready_o} !== 2'b11) begin
         failed++; $display("FAIL reset idle/ready: got %b want 11", {analog_rx_idle_o, spin_ready_o});
      end
      @(negedge clk_i); rst_i = 0;
   endtask

   task automatic test_basic();
      int l, s, c, r;
      exp_q.push_back('{pat(8'hA5), 16});
      run_hs(pat(8'hA5), 0, -1, 0, l, s, c, r);
      check_run("basic", l, s, c);
      repeat (3) @(negedge clk_i);
      tests_run++;
      if (analog_macro_cmpt_finish_o !== 1'b1) begin failed++; $display("FAIL finish hold: got %b want 1", analog_macro_cmpt_finish_o); end
   endtask

   task automatic test_config();
      int l, s, c, r;
      cfg(8'd3);
      exp_q.push_back('{pat(8'h3C), 3});
      run_hs(pat(8'h3C), 0, -1, 0, l, s, c, r);
      check_run("cfg3", l, s, c);
      cfg(8'd0);
      exp_q.push_back('{pat(8'h01), 1});
      run_hs(pat(8'h01), 0, -1, 0, l, s, c, r);
      check_run("cfg0", l, s, c);
      rx_configure_enable_i = 1; cmpt_cycles_i = 8'd7;
      exp_q.push_back('{pat(8'h77), 7});
      run_hs(pat(8'h77), 0, -1, 0, l, s, c, r);
      check_run("cfg_same_edge", l, s, c);
   endtask

   task automatic test_cfg_during_cmpt();
      int l, s, c, r;
      exp_q.push_back('{pat(8'h5A), 7});
      run_hs(pat(8'h5A), 0, 3, 8'd5, l, s, c, r);
      check_run("cfg_in_cmpt", l, s, c);
      exp_q.push_back('{pat(8'h69), 7});
      run_hs(pat(8'h69), 0, -1, 0, l, s, c, r);
      check_run("cfg_in_cmpt_next", l, s, c);
   endtask

   task automatic test_back_to_back();
      int l, s, c, r, n;
      exp_q.push_back('{pat(8'h11), 7});
      run_hs(pat(8'h11), 1, -1, 0, l, s, c, r);
      check_run("b2b_first", l, s, c);
      tests_run++;
      if (r !== 0) begin failed++; $display("FAIL b2b ready while busy: got %0d want 0", r); end
      tests_run++;
      if (spin_ready_o !== 1'b1) begin failed++; $display("FAIL b2b ready in idle: got %b want 1", spin_ready_o); end
      spin_i = pat(8'h22);
      exp_q.push_back('{pat(8'h22), 7});
      @(posedge clk_i);
      @(negedge clk_i);
      spin_valid_i = 0;
      tests_run++;
      if ({analog_macro_cmpt_finish_o, analog_macro_load_o} !== 2'b01) begin
         failed++; $display("FAIL b2b finish clear/load: got %b want 01", {analog_macro_cmpt_finish_o, analog_macro_load_o});
      end
      s = 0; n = 1;
      while (analog_macro_cmpt_finish_o !== 1'b1 && n < 600) begin
         s += int'(analog_macro_start_o);
         @(negedge clk_i);
         n++;
      end
      check_run("b2b_second", 1, s, n);
   endtask

   task automatic test_en_low();
      int f, l, s, c, r;
      spin_i = pat(8'hC3); spin_valid_i = 1;
      @(posedge clk_i);
      @(negedge clk_i);
      spin_valid_i = 0;
      repeat (4) @(negedge clk_i);
      en_i = 0;
      @(posedge clk_i);
      @(negedge clk_i);
      tests_run++;
      if ({analog_macro_start_o, analog_macro_load_o, analog_macro_cmpt_finish_o, analog_rx_idle_o} !== 4'b0001) begin
         failed++; $display("FAIL en_low state: got %b want 0001", {analog_macro_start_o, analog_macro_load_o, analog_macro_cmpt_finish_o, analog_rx_idle_o});
      end
      tests_run++;
      if (spin_o !== pat(8'hC3)) begin failed++; $display("FAIL en_low spin_o: got %h want c3..", spin_o[31:0]); end
      en_i = 1; f = 0;
      repeat (20) begin @(negedge clk_i); f += int'(analog_macro_cmpt_finish_o); end
      tests_run++;
      if (f !== 0) begin failed++; $display("FAIL en_low finish: got %0d want 0", f); end
      exp_q.push_back('{pat(8'h96), 7});
      run_hs(pat(8'h96), 0, -1, 0, l, s, c, r);
      check_run("en_low_after", l, s, c);
   endtask

   task automatic test_rst_mid();
      int f, l, s, c, r;
      spin_i = pat(8'hE7); spin_valid_i = 1;
      @(posedge clk_i);
      @(negedge clk_i);
      spin_valid_i = 0;
      repeat (4) @(negedge clk_i);
      #2 rst_i = 1;
      #1;
      tests_run++;
      if ({spin_o != '0, analog_macro_load_o, analog_macro_start_o, analog_macro_cmpt_finish_o, analog_rx_idle_o} !== 5'b00001) begin
         failed++; $display("FAIL rst_mid outputs: got %b want 00001", {spin_o != '0, analog_macro_load_o, analog_macro_start_o, analog_macro_cmpt_finish_o, analog_rx_idle_o});
      end
      @(negedge clk_i); rst_i = 0; f = 0;
      repeat (20) begin @(negedge clk_i); f += int'(analog_macro_cmpt_finish_o); end
      tests_run++;
      if (f !== 0) begin failed++; $display("FAIL rst_mid finish: got %0d want 0", f); end
      exp_q.push_back('{pat(8'h4B), 16});
      run_hs(pat(8'h4B), 0, -1, 0, l, s, c, r);
      check_run("rst_default_cycles", l, s, c);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_config();
      test_cfg_during_cmpt();
      test_back_to_back();
      test_en_low();
      test_rst_mid();
      tests_run++;
      if (exp_q.size() !== 0) begin failed++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule

// File: doc/analog_rx.md
ANALOG_RX -- requirements
Module: analog_rx

Interface
REQ-001 SHALL have parameter num_spin, default 256: spin vector width.
REQ-002 SHALL have parameter counter_bitwidth, default 8: width of the compute-duration counter and config field.
REQ-003 SHALL have parameter default_cmpt_cycles, default 16: reset value of the stored compute duration.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en_i  input  1  block enable.
REQ-007 SHALL have port rx_configure_enable_i  input  1  config load strobe.
REQ-008 SHALL have port cmpt_cycles_i  input  counter_bitwidth  compute-duration config value.
REQ-009 SHALL have port spin_valid_i  input  1  spin vector valid from digital.
REQ-010 SHALL have port spin_ready_o  output  1  ready to accept a spin vector.
REQ-011 SHALL have port spin_i  input  num_spin  spin vector from digital.
REQ-012 SHALL have port spin_o  output  num_spin  registered spin vector to analog macro.
REQ-013 SHALL have port analog_macro_load_o  output  1  spin load strobe to analog macro.
REQ-014 SHALL have port analog_macro_start_o  output  1  compute-active level to analog macro.
REQ-015 SHALL have port analog_macro_cmpt_finish_o  output  1  compute-done level to the downstream TX stage.
REQ-016 SHALL have port analog_rx_idle_o  output  1  high when in IDLE.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, LOAD, CMPT.
REQ-018 SHALL drive spin_ready_o = en_i and state==IDLE, combinationally.
REQ-019 SHALL define handshake as spin_valid_i and spin_ready_o at a rising edge; spin_valid_i without ready SHALL NOT change state.
REQ-020 On handshake at edge k, SHALL capture spin_i into spin_o and enter LOAD at edge k.
REQ-021 In LOAD, SHALL assert analog_macro_load_o for exactly one cycle, then enter CMPT.
REQ-022 In CMPT, SHALL assert analog_macro_start_o and stay for exactly N cycles, N = cmpt_cycles_reg, with value 0 treated as 1.
REQ-023 SHALL count CMPT cycles with a counter_bitwidth counter that starts at 1 on CMPT entry, increments by 1 each cycle, and never wraps.
REQ-024 At the edge ending the last CMPT cycle, SHALL return to IDLE and set analog_macro_cmpt_finish_o to 1.
REQ-025 Timing: handshake at edge k gives load high during cycle k..k+1, start high during cycles k+1..k+1+N, and cmpt_finish_o rising at edge k+1+N.
REQ-026 SHALL hold analog_macro_cmpt_finish_o high in IDLE until the next handshake, then clear it at that same edge, so the downstream stage sees one rising edge per computation.
REQ-027 SHALL hold spin_o stable from capture until the next handshake.
REQ-028 SHALL load cmpt_cycles_reg from cmpt_cycles_i when en_i, rx_configure_enable_i and state==IDLE; config strobes in LOAD or CMPT SHALL be ignored.
REQ-029 Config strobe and handshake at the same IDLE edge: SHALL apply the new value to the computation just started.
REQ-030 SHALL sample N for the running computation from cmpt_cycles_reg on CMPT entry.
REQ-031 en_i low at any edge SHALL force the FSM to IDLE and clear the counter, load_o, start_o and cmpt_finish_o; spin_o and cmpt_cycles_reg SHALL be retained.
REQ-032 analog_rx_idle_o SHALL equal (state==IDLE).

Reset
REQ-033 On rst_i high, SHALL asynchronously set: state=IDLE, spin_o=0, load_o=0, start_o=0, cmpt_finish_o=0, counter=0, cmpt_cycles_reg=default_cmpt_cycles.
REQ-034 Reset asserted mid-LOAD or mid-CMPT SHALL abort the computation immediately with no cmpt_finish_o pulse.
REQ-035 After rst_i deasserts, SHALL accept a handshake at the first edge with en_i high.

Verification
REQ-036 Reset, en_i=1, spin_valid_i=1, spin_i=0xA5..A5 -> spin_o=0xA5..A5 after the edge; load_o high 1 cycle; start_o high 16 cycles; cmpt_finish_o rises at edge 17 after the handshake.
REQ-037 Config cmpt_cycles_i=3 in IDLE, then handshake -> start_o high 3 cycles; config value 0 -> start_o high 1 cycle.
REQ-038 Config strobe with cmpt_cycles_i=5 during CMPT -> current run unaffected; next run uses prior value.
REQ-039 spin_valid_i held high through a computation -> ready low in LOAD and CMPT; second vector accepted only in IDLE, and cmpt_finish_o clears at that edge.
REQ-040 en_i low mid-CMPT -> IDLE next edge, start_o=0, cmpt_finish_o stays 0, spin_o unchanged.
REQ-041 rst_i pulsed mid-CMPT -> all outputs 0 immediately, cmpt_cycles_reg=16, and no finish edge observed.
